// File: rtl/gps_pkg.sv
// Shared types and constants for the GPS code sequencer: FSM states, default
// capture lengths and the lowest-set-bit channel picker.
package gps_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StCapture,
    StOffer,
    StDone
  } gps_state_e;

  localparam int unsigned GPS_CA_BITS = 13;
  localparam int unsigned GPS_P_BITS  = 128;
  localparam int unsigned GPS_MAX_CH  = 16;

  // Index of the lowest set bit; returns 0 for an empty mask.
  function automatic logic [3:0] lowest_set(input logic [GPS_MAX_CH-1:0] mask);
    logic [3:0] idx;
    idx = '0;
    for (int i = GPS_MAX_CH - 1; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gps_code_sequencer_if.sv
// Valid/ready block interface from the code sequencer to the L-code encryptor.
interface gps_code_sequencer_if
  import gps_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CA_BITS = GPS_CA_BITS,
  parameter int unsigned P_BITS  = GPS_P_BITS
);
  localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic               out_valid;
  logic               out_ready;
  logic [ChW-1:0]     out_ch;
  logic [CA_BITS-1:0] out_ca;
  logic [P_BITS-1:0]  out_p;

  modport master (
    output out_valid,
    output out_ch,
    output out_ca,
    output out_p,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_ch,
    input  out_ca,
    input  out_p,
    output out_ready
  );

endinterface

// File: rtl/gps_shift_capture.sv
// MSB-first capture shift register with a saturating sample count; stops
// shifting once Width samples have been taken.
module gps_shift_capture #(
  parameter int unsigned Width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       enable_i,
  input  logic                       bit_in_i,
  output logic [Width-1:0]           data_o,
  output logic [$clog2(Width+1)-1:0] count_o,
  output logic                       full_o
);
  localparam int unsigned CntW = $clog2(Width + 1);

  logic [Width-1:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             full;

  assign full = (cnt_q == CntW'(Width));

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (enable_i && !full) begin
      data_d = (data_q << 1) | Width'(bit_in_i);
      cnt_d  = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o  = data_q;
  assign count_o = cnt_q;
  assign full_o  = full;

endmodule

// File: rtl/gps_code_sequencer.sv
// Sequences the enabled C/A + P code generator channels in turn, captures one
// block per channel and offers it downstream over a valid/ready handshake.
module gps_code_sequencer
  import gps_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CA_BITS = GPS_CA_BITS,
  parameter int unsigned P_BITS  = GPS_P_BITS
) (
  input  logic               gps_clk,
  input  logic               gps_rst_n,
  input  logic               start_round,
  input  logic [NUM_CH-1:0]  ch_mask,
  input  logic [NUM_CH-1:0]  ca_bit_in,
  input  logic [NUM_CH-1:0]  p_bit_in,
  output logic [NUM_CH-1:0]  gen_en,
  output logic               busy,
  output logic               round_done,
  gps_code_sequencer_if.master out_if
);
  localparam int unsigned ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PCntW  = $clog2(P_BITS + 1);
  localparam int unsigned CaCntW = $clog2(CA_BITS + 1);

  gps_state_e        state_q, state_d;
  logic              start_r_q;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [ChW-1:0]    ch_q, ch_d;

  logic              start_edge;
  logic [NUM_CH-1:0] ch_onehot;
  logic [NUM_CH-1:0] mask_rem;
  logic              capture_clear;
  logic              capture_en;
  logic              p_last;

  logic [CA_BITS-1:0] ca_data;
  logic [P_BITS-1:0]  p_data;
  logic [CaCntW-1:0]  ca_cnt;
  logic [PCntW-1:0]   p_cnt;
  logic               ca_full;
  logic               p_full;

  assign start_edge    = start_round & ~start_r_q;
  assign ch_onehot     = NUM_CH'(1) << ch_q;
  assign mask_rem      = mask_q & ~ch_onehot;
  assign capture_clear = (state_q == StArm);
  assign capture_en    = (state_q == StCapture);
  assign p_last        = capture_en && (p_cnt == PCntW'(P_BITS - 1));

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    ch_d    = ch_q;
    case (state_q)
      StIdle:    state_d = StIdle;
      StArm:     state_d = StCapture;
      StCapture: if (p_last) state_d = StOffer;
      StOffer: begin
        if (out_if.out_ready) begin
          mask_d  = mask_rem;
          ch_d    = ChW'(lowest_set(GPS_MAX_CH'(mask_rem)));
          state_d = (mask_rem != '0) ? StArm : StDone;
        end
      end
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    // A new start edge wins in every state, aborting any round in flight.
    if (start_edge) begin
      mask_d  = ch_mask;
      ch_d    = ChW'(lowest_set(GPS_MAX_CH'(ch_mask)));
      state_d = (ch_mask != '0) ? StArm : StDone;
    end
  end

  always_ff @(posedge gps_clk or negedge gps_rst_n) begin
    if (!gps_rst_n) begin
      state_q   <= StIdle;
      start_r_q <= 1'b0;
      mask_q    <= '0;
      ch_q      <= '0;
    end else begin
      state_q   <= state_d;
      start_r_q <= start_round;
      mask_q    <= mask_d;
      ch_q      <= ch_d;
    end
  end

  // Gate with start_edge so an abort drops the generator and the offer at once.
  always_comb begin
    gen_en           = '0;
    out_if.out_valid = 1'b0;
    if ((state_q == StArm || state_q == StCapture) && !start_edge) gen_en = ch_onehot;
    if (state_q == StOffer && !start_edge) out_if.out_valid = 1'b1;
  end

  assign busy          = (state_q != StIdle);
  assign round_done    = (state_q == StDone);
  assign out_if.out_ch = ch_q;
  assign out_if.out_ca = ca_data;
  assign out_if.out_p  = p_data;

  gps_shift_capture #(
    .Width (CA_BITS)
  ) u_ca_capture (
    .clk_i    (gps_clk),
    .rst_ni   (gps_rst_n),
    .clear_i  (capture_clear),
    .enable_i (capture_en),
    .bit_in_i (ca_bit_in[ch_q]),
    .data_o   (ca_data),
    .count_o  (ca_cnt),
    .full_o   (ca_full)
  );

  gps_shift_capture #(
    .Width (P_BITS)
  ) u_p_capture (
    .clk_i    (gps_clk),
    .rst_ni   (gps_rst_n),
    .clear_i  (capture_clear),
    .enable_i (capture_en),
    .bit_in_i (p_bit_in[ch_q]),
    .data_o   (p_data),
    .count_o  (p_cnt),
    .full_o   (p_full)
  );

  logic unused_capture;
  assign unused_capture = ^{ca_cnt, ca_full, p_full};

endmodule

// File: tb/tb_gps_code_sequencer.sv
// Scoreboard bench for gps_code_sequencer: expected blocks are queued by the
// stimulus and popped by a monitor on each accepted handshake.
module tb_gps_code_sequencer;
  import gps_pkg::*;

  localparam int unsigned NumCh  = 4;
  localparam int unsigned CaBits = 13;
  localparam int unsigned PBits  = 128;

  typedef struct packed {
    logic [1:0]        ch;
    logic [CaBits-1:0] ca;
    logic [PBits-1:0]  p;
  } blk_t;

  logic             gps_clk = 1'b0;
  logic             gps_rst_n = 1'b0;
  logic             start_round = 1'b0;
  logic [NumCh-1:0] ch_mask = '0;
  logic [NumCh-1:0] ca_bit_in = '0;
  logic [NumCh-1:0] p_bit_in = '0;
  logic [NumCh-1:0] gen_en;
  logic             busy;
  logic             round_done;

  gps_code_sequencer_if #(
    .NUM_CH  (NumCh),
    .CA_BITS (CaBits),
    .P_BITS  (PBits)
  ) out_if ();

  gps_code_sequencer #(
    .NUM_CH  (NumCh),
    .CA_BITS (CaBits),
    .P_BITS  (PBits)
  ) dut (
    .gps_clk     (gps_clk),
    .gps_rst_n   (gps_rst_n),
    .start_round (start_round),
    .ch_mask     (ch_mask),
    .ca_bit_in   (ca_bit_in),
    .p_bit_in    (p_bit_in),
    .gen_en      (gen_en),
    .busy        (busy),
    .round_done  (round_done),
    .out_if      (out_if.master)
  );

  initial forever #5 gps_clk = ~gps_clk;

  blk_t             exp_q[$];
  blk_t             mon_e;
  int               checks = 0;
  int               errors = 0;
  int               rd_count = 0;
  int               rd_before = 0;
  int               mode = 0;
  int               n = 0;
  logic [NumCh-1:0] gen_prev = '0;

  localparam logic [PBits-1:0] AllOnes = '1;
  localparam logic [PBits-1:0] PatA = {(PBits / 4){4'hA}};
  localparam logic [PBits-1:0] Pat5 = {(PBits / 4){4'h5}};

  task automatic check(input string name, input logic [PBits-1:0] act,
                       input logic [PBits-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge gps_clk);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [CaBits-1:0] ca,
                      input logic [PBits-1:0] p);
    blk_t b;
    b.ch = ch;
    b.ca = ca;
    b.p  = p;
    exp_q.push_back(b);
  endtask

  // Raises start_round with the given mask; returns just after E0.
  task automatic start(input logic [NumCh-1:0] m);
    ch_mask     = m;
    start_round = 1'b1;
    tick(1);
    start_round = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!out_if.out_valid && k < 400) begin
      tick(1);
      k++;
    end
    check(name, out_if.out_valid, 1);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!round_done && k < 1000) begin
      tick(1);
      k++;
    end
    check(name, round_done, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_gen_en"}, gen_en, 0);
    check({tag, "_valid"}, out_if.out_valid, 0);
    check({tag, "_ch"}, out_if.out_ch, 0);
    check({tag, "_ca"}, out_if.out_ca, 0);
    check({tag, "_p"}, out_if.out_p, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_round_done"}, round_done, 0);
  endtask

  // Code generator model: sample k of a block sees count k+1, so count[0] = 1
  // on the first sample. Unselected channels get the inverted bit.
  initial begin
    logic [NumCh-1:0] seen;
    int               gcnt;
    logic             b_ca, b_p;
    gcnt = 0;
    forever begin
      @(negedge gps_clk);
      seen = gen_en;
      @(posedge gps_clk);
      #1;
      gcnt = (seen != '0) ? gcnt + 1 : 0;
      case (mode)
        1:       begin b_ca = gcnt[0]; b_p = gcnt[0];  end
        2:       begin b_ca = gcnt[0]; b_p = ~gcnt[0]; end
        default: begin b_ca = 1'b1;    b_p = 1'b1;     end
      endcase
      ca_bit_in = b_ca ? seen : ~seen;
      p_bit_in  = b_p ? seen : ~seen;
    end
  end

  // Monitor: block scoreboard, round_done pulse count, gen_en one-hot/gap.
  initial forever begin
    @(negedge gps_clk);
    if (round_done) rd_count++;
    if (out_if.out_valid && out_if.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block actual ch %0d required no block", out_if.out_ch);
      end else begin
        mon_e = exp_q.pop_front();
        check("blk_ch", out_if.out_ch, mon_e.ch);
        check("blk_ca", out_if.out_ca, mon_e.ca);
        check("blk_p", out_if.out_p, mon_e.p);
      end
    end
    if (gen_en !== gen_prev) begin
      check("gen_onehot0", $onehot0(gen_en), 1);
      check("gen_gap", (gen_prev != '0) && (gen_en != '0), 0);
    end
    gen_prev = gen_en;
  end

  initial begin
    out_if.out_ready = 1'b1;
    tick(3);
    check_reset_values("reset");
    gps_rst_n = 1'b1;
    tick(2);

    // Single channel, all-ones code.
    mode = 0;
    push(2'd0, 13'h1FFF, AllOnes);
    start(4'b0001);
    check("t1_gen_en_e0", gen_en, 4'b0001);
    check("t1_busy_e0", busy, 1);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!out_if.out_valid && n < 400);
    check("t1_valid_latency", n, 129);
    tick(1);
    check("t1_round_done", round_done, 1);
    check("t1_valid_after_hs", out_if.out_valid, 0);
    tick(1);
    check("t1_round_done_low", round_done, 0);
    check("t1_busy_low", busy, 0);

    // Two channels back to back, alternating code.
    mode = 1;
    push(2'd1, 13'h1555, PatA);
    push(2'd3, 13'h1555, PatA);
    start(4'b1010);
    check("t2_gen_en_e0", gen_en, 4'b0010);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!round_done && n < 1000);
    check("t2_round_length", n, 2 * (PBits + 2));
    tick(2);

    // Stall in OFFER for 20 cycles.
    mode = 2;
    out_if.out_ready = 1'b0;
    push(2'd2, 13'h1555, Pat5);
    start(4'b0100);
    wait_valid("t3_valid_seen");
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("t3_hold_valid", out_if.out_valid, 1);
      check("t3_hold_ch", out_if.out_ch, 2);
      check("t3_hold_ca", out_if.out_ca, 13'h1555);
      check("t3_hold_p", out_if.out_p, Pat5);
      check("t3_hold_gen_en", gen_en, 0);
    end
    out_if.out_ready = 1'b1;
    tick(1);
    check("t3_round_done", round_done, 1);
    tick(2);

    // Abort mid-capture on ch 2, restart on ch 0.
    mode = 1;
    start(4'b0100);
    tick(50);
    check("t4_gen_en_ch2", gen_en, 4'b0100);
    rd_before = rd_count;
    ch_mask = 4'b0001;
    start_round = 1'b1;
    #2;
    check("t4_gen_en_drop", gen_en, 0);
    push(2'd0, 13'h1555, PatA);
    tick(1);
    start_round = 1'b0;
    check("t4_gen_en_ch0", gen_en, 4'b0001);
    check("t4_busy", busy, 1);
    wait_done("t4_done_seen");
    tick(2);
    check("t4_one_round_done", rd_count - rd_before, 1);

    // Empty mask.
    rd_before = rd_count;
    start(4'b0000);
    check("t5_busy_e0", busy, 1);
    check("t5_round_done_e0", round_done, 1);
    check("t5_valid_e0", out_if.out_valid, 0);
    tick(1);
    check("t5_busy_e1", busy, 0);
    check("t5_round_done_e1", round_done, 0);
    tick(1);
    check("t5_one_round_done", rd_count - rd_before, 1);

    // Asynchronous reset while offering, then a clean round.
    mode = 0;
    out_if.out_ready = 1'b0;
    start(4'b0001);
    wait_valid("t6_valid_seen");
    #2;
    gps_rst_n = 1'b0;
    #1;
    check_reset_values("t6_async");
    tick(1);
    gps_rst_n = 1'b1;
    tick(1);
    out_if.out_ready = 1'b1;
    push(2'd0, 13'h1FFF, AllOnes);
    start(4'b0001);
    wait_done("t6_done_seen");
    tick(3);

    check("scoreboard_empty", exp_q.size(), 0);
    check("round_done_total", rd_count, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
